// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: sequencer state encoding and the default stage indices of the
// five-stage fetch/regfetch/execute/memory/writeback loop.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_STAGE  = 2'd1,
        SEQ_HALTED = 2'd2
    } seq_state_e;

    localparam int STG_IF  = 0;
    localparam int STG_RF  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/multicycle_stage_sequencer_if.sv
// multicycle_stage_sequencer_if: control bundle between the stage sequencer
// (master) and the multicycle datapath / data memory (slave).
interface multicycle_stage_sequencer_if #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
);
    localparam int IDX_W = $clog2(NUM_STAGES);

    logic                  run;
    logic                  halt;
    logic                  flush;
    logic                  cond_pass;
    logic                  mem_ready;
    logic [NUM_STAGES-1:0] stage_en;
    logic [IDX_W-1:0]      stage_idx;
    logic                  mem_req;
    logic                  busy;
    logic                  instr_done;
    logic                  mem_err;
    logic [CNT_W-1:0]      retired_cnt;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        input  run, halt, flush, cond_pass, mem_ready,
        output stage_en, stage_idx, mem_req, busy, instr_done, mem_err,
               retired_cnt, stall_cnt
    );

    modport slave (
        output run, halt, flush, cond_pass, mem_ready,
        input  stage_en, stage_idx, mem_req, busy, instr_done, mem_err,
               retired_cnt, stall_cnt
    );

endinterface

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: saturating wait counter; expired_o is high once TIMEOUT
// enabled cycles have accumulated since the last clear.
module seq_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// multicycle_stage_sequencer: one-hot stage-enable sequencer with mem handshake/timeout,
// condition skip, flush and halt. Define MSS_PERF_CNT_EN to build the stall_cnt counter.
module multicycle_stage_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int NUM_STAGES = STG_WB + 1,
    parameter int EXEC_STAGE = STG_EX,
    parameter int MEM_STAGE  = STG_MEM,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 32
) (
    input logic                          clk,
    input logic                          nreset,
    multicycle_stage_sequencer_if.master seq
);
    localparam int               IDX_W    = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(STG_IF);
    localparam logic [IDX_W-1:0] EXEC_IDX = IDX_W'(EXEC_STAGE);
    localparam logic [IDX_W-1:0] MEM_IDX  = IDX_W'(MEM_STAGE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      stage_q, stage_d;
    logic                  halt_pend_q, halt_pend_d;
    logic                  mem_err_q, mem_err_d;
    logic                  retire;
    logic [NUM_STAGES-1:0] stage_en_q;
    logic                  mem_req_q;
    logic                  busy_q;
    logic                  instr_done_q;
    logic [CNT_W-1:0]      retired_cnt_q;
    logic                  in_mem;
    logic                  mem_expired;

    assign in_mem = (state_q == SEQ_STAGE) && (stage_q == MEM_IDX);

    seq_timeout_counter #(.TIMEOUT(TIMEOUT)) u_mem_wait (
        .clk       (clk),
        .rst_n     (nreset),
        .clr_i     (!in_mem || seq.flush),
        .en_i      (in_mem && !seq.mem_ready),
        .expired_o (mem_expired)
    );

    // Same-edge priority: flush, then timeout, then mem handshake, then cond skip / retire.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        halt_pend_d = halt_pend_q;
        mem_err_d   = mem_err_q;
        retire      = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (seq.run && !seq.halt) begin
                    state_d = SEQ_STAGE;
                    stage_d = FIRST_IDX;
                end
            end
            SEQ_STAGE: begin
                halt_pend_d = halt_pend_q | seq.halt;
                if (seq.flush) begin
                    stage_d = FIRST_IDX;
                    if (!seq.run) begin
                        state_d     = SEQ_IDLE;
                        halt_pend_d = 1'b0;
                    end
                end else if (in_mem) begin
                    if (mem_expired) begin
                        state_d   = SEQ_HALTED;
                        stage_d   = '0;
                        mem_err_d = 1'b1;
                    end else if (seq.mem_ready) begin
                        stage_d = stage_q + 1'b1;
                    end
                end else if (((stage_q == EXEC_IDX) && !seq.cond_pass) || (stage_q == LAST_IDX)) begin
                    retire      = 1'b1;
                    stage_d     = '0;
                    halt_pend_d = 1'b0;
                    if (seq.halt || halt_pend_q) begin
                        state_d = SEQ_HALTED;
                    end else if (seq.run) begin
                        state_d = SEQ_STAGE;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            SEQ_HALTED: begin
                state_d = SEQ_HALTED;
            end
            default: begin
                state_d = SEQ_IDLE;
                stage_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the stage they describe.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= SEQ_IDLE;
            stage_q       <= '0;
            halt_pend_q   <= 1'b0;
            mem_err_q     <= 1'b0;
            stage_en_q    <= '0;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            instr_done_q  <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            halt_pend_q   <= halt_pend_d;
            mem_err_q     <= mem_err_d;
            stage_en_q    <= (state_d == SEQ_STAGE) ? (NUM_STAGES'(1) << stage_d) : '0;
            mem_req_q     <= (state_d == SEQ_STAGE) && (stage_d == MEM_IDX);
            busy_q        <= (state_d == SEQ_STAGE);
            instr_done_q  <= retire;
            retired_cnt_q <= retired_cnt_q + CNT_W'(retire);
        end
    end

`ifdef MSS_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stall_cnt_q <= '0;
        end else if (in_mem && mem_req_q && !seq.mem_ready) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign seq.stall_cnt = stall_cnt_q;
`else
    assign seq.stall_cnt = '0;
`endif

    assign seq.stage_en    = stage_en_q;
    assign seq.stage_idx   = stage_q;
    assign seq.mem_req     = mem_req_q;
    assign seq.busy        = busy_q;
    assign seq.instr_done  = instr_done_q;
    assign seq.mem_err     = mem_err_q;
    assign seq.retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Directed bench for multicycle_stage_sequencer with default parameters; stall_cnt
// expectations follow MSS_PERF_CNT_EN.
module tb_multicycle_stage_sequencer;
    localparam int NS = 5;
    localparam int CW = 32;
`ifdef MSS_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk;
    logic nreset;
    int   n_checks;
    int   n_errors;

    multicycle_stage_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) sif ();

    multicycle_stage_sequencer dut (
        .clk    (clk),
        .nreset (nreset),
        .seq    (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_en;
        n_checks = 0;
        n_errors = 0;
        nreset = 1'b0;
        sif.run = 1'b0;
        sif.halt = 1'b0;
        sif.flush = 1'b0;
        sif.cond_pass = 1'b1;
        sif.mem_ready = 1'b1;
        step();
        step();
        check("rst_stage_en", sif.stage_en, 0);
        check("rst_stage_idx", sif.stage_idx, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_mem_req", sif.mem_req, 0);
        check("rst_done", sif.instr_done, 0);
        check("rst_mem_err", sif.mem_err, 0);
        check("rst_retired", sif.retired_cnt, 0);
        check("rst_stall", sif.stall_cnt, 0);
        nreset = 1'b1;
        step();
        check("idle_stays", sif.busy, 0);

        // Two back-to-back instructions
        sif.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_en = 64'd1 << (i % NS);
            check("walk_en", sif.stage_en, exp_en);
            check("walk_idx", sif.stage_idx, i % NS);
            check("walk_done", sif.instr_done, (i == 5) ? 1 : 0);
            check("walk_mem_req", sif.mem_req, ((i % NS) == 3) ? 1 : 0);
        end
        sif.run = 1'b0;
        step();
        check("walk_last_done", sif.instr_done, 1);
        check("walk_retired", sif.retired_cnt, 2);
        check("walk_idle_en", sif.stage_en, 0);
        check("walk_idle_busy", sif.busy, 0);

        // Condition fail in EX
        sif.cond_pass = 1'b0;
        sif.run = 1'b1;
        step();
        check("skip_en0", sif.stage_en, 5'b00001);
        sif.run = 1'b0;
        step();
        check("skip_en1", sif.stage_en, 5'b00010);
        step();
        check("skip_en2", sif.stage_en, 5'b00100);
        check("skip_no_req", sif.mem_req, 0);
        step();
        check("skip_done", sif.instr_done, 1);
        check("skip_retired", sif.retired_cnt, 3);
        check("skip_no_req2", sif.mem_req, 0);
        check("skip_idle_en", sif.stage_en, 0);
        step();
        check("skip_done_pulse", sif.instr_done, 0);

        // Memory wait of three cycles
        sif.cond_pass = 1'b1;
        sif.mem_ready = 1'b0;
        sif.run = 1'b1;
        step();
        sif.run = 1'b0;
        step();
        step();
        step();
        check("wait_req_c1", sif.mem_req, 1);
        check("wait_en_c1", sif.stage_en, 5'b01000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req_hold", sif.mem_req, 1);
            check("wait_en_hold", sif.stage_en, 5'b01000);
        end
        sif.mem_ready = 1'b1;
        step();
        check("wait_wb_en", sif.stage_en, 5'b10000);
        check("wait_req_drop", sif.mem_req, 0);
        check("wait_stall", sif.stall_cnt, (PERF != 0) ? 3 : 0);
        step();
        check("wait_done", sif.instr_done, 1);
        check("wait_retired", sif.retired_cnt, 4);

        // Flush while waiting in MEM
        sif.mem_ready = 1'b0;
        sif.run = 1'b1;
        step();
        step();
        step();
        step();
        check("flush_pre_req", sif.mem_req, 1);
        sif.flush = 1'b1;
        step();
        check("flush_en", sif.stage_en, 5'b00001);
        check("flush_req", sif.mem_req, 0);
        check("flush_done", sif.instr_done, 0);
        check("flush_retired", sif.retired_cnt, 4);
        sif.run = 1'b0;
        step();
        check("flush_idle_en", sif.stage_en, 0);
        check("flush_idle_busy", sif.busy, 0);
        sif.flush = 1'b0;

        // Halt requested in stage 1
        sif.mem_ready = 1'b1;
        sif.run = 1'b1;
        step();
        step();
        check("halt_s1", sif.stage_en, 5'b00010);
        sif.halt = 1'b1;
        step();
        sif.halt = 1'b0;
        step();
        step();
        check("halt_s4", sif.stage_en, 5'b10000);
        step();
        check("halt_done", sif.instr_done, 1);
        check("halt_retired", sif.retired_cnt, 5);
        check("halt_en", sif.stage_en, 0);
        check("halt_busy", sif.busy, 0);
        step();
        check("halted_en", sif.stage_en, 0);
        check("halted_done", sif.instr_done, 0);

        // Reset mid-stage 2
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        step();
        step();
        step();
        check("mid_s2_en", sif.stage_en, 5'b00100);
        check("mid_s2_busy", sif.busy, 1);
        #2;
        nreset = 1'b0;
        #1;
        check("arst_en", sif.stage_en, 0);
        check("arst_idx", sif.stage_idx, 0);
        check("arst_busy", sif.busy, 0);
        check("arst_retired", sif.retired_cnt, 0);
        @(negedge clk);
        nreset = 1'b1;

        // Memory timeout
        sif.mem_ready = 1'b0;
        step();
        check("to_s0", sif.stage_en, 5'b00001);
        sif.run = 1'b0;
        step();
        step();
        step();
        check("to_req_c1", sif.mem_req, 1);
        for (int i = 0; i < 16; i++) begin
            step();
            check("to_req_hold", sif.mem_req, 1);
            check("to_no_err", sif.mem_err, 0);
        end
        step();
        check("to_mem_err", sif.mem_err, 1);
        check("to_busy", sif.busy, 0);
        check("to_req_drop", sif.mem_req, 0);
        check("to_en", sif.stage_en, 0);
        check("to_done", sif.instr_done, 0);
        check("to_retired", sif.retired_cnt, 0);
        check("to_stall", sif.stall_cnt, (PERF != 0) ? 17 : 0);
        sif.run = 1'b1;
        step();
        check("to_halted_en", sif.stage_en, 0);
        check("to_err_sticky", sif.mem_err, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
